// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the 16B line memory responder: message formats,
// request type encodings, line width and FSM state encoding.
package line_mem_responder_pkg;

    localparam int LINE_W = 128;

    localparam logic [2:0] MEM_TYPE_READ       = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE      = 3'd1;
    localparam logic [2:0] MEM_TYPE_WRITE_INIT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]        type_;
        logic [7:0]        opaque;
        logic [31:0]       addr;
        logic [3:0]        len;
        logic [LINE_W-1:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]        type_;
        logic [7:0]        opaque;
        logic [1:0]        test;
        logic [3:0]        len;
        logic [LINE_W-1:0] data;
    } mem_resp_16B_t;

    // Both write flavours update the line store identically.
    function automatic logic is_write(input logic [2:0] t);
        return (t == MEM_TYPE_WRITE) || (t == MEM_TYPE_WRITE_INIT);
    endfunction

endpackage

// File: rtl/line_mem_latency_ctr.sv
// Load/decrement counter that paces the response latency; done flags the
// last waiting cycle (count of one).
module line_mem_latency_ctr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Counter register: load has priority over decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the 16B line protocol: one outstanding request,
// full-line read/write on an internal store, response after p_latency cycles.
// Optional accepted-request counters are built when LINE_MEM_STATS_EN is defined.
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    input  mem_req_16B_t  memreq_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy,
    output mem_resp_16B_t memresp_msg
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]   num_reads,
    output logic [31:0]   num_writes
`endif
);

    localparam int IDX_W = $clog2(p_num_lines);
    localparam int CNT_W = (p_latency < 2) ? 1 : $clog2(p_latency);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              ctr_load;
    logic              ctr_dec;
    logic              ctr_done;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] store [p_num_lines];
    logic              unused_req_bits;

    // Low address nibble, high address bits and len never affect the access.
    assign unused_req_bits = ^{memreq_msg.addr, memreq_msg.len};

    assign idx        = memreq_msg.addr[4+IDX_W-1:4];
    assign memreq_rdy = (state == ST_IDLE) && !reset;
    assign accept     = memreq_val && memreq_rdy;

    line_mem_latency_ctr #(.CNT_W(CNT_W)) u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (CNT_W'(p_latency - 1)),
        .dec      (ctr_dec),
        .done     (ctr_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        ctr_load    = 1'b0;
        ctr_dec     = 1'b0;
        memresp_val = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ctr_load   = 1'b1;
                    state_next = (p_latency == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                ctr_dec = 1'b1;
                if (ctr_done)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line store write; contents survive reset so committed writes persist.
    always_ff @(posedge clk) begin
        if (accept && is_write(memreq_msg.type_))
            store[idx] <= memreq_msg.data;
    end

    // Response message captured on accept and held until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memresp_msg <= '0;
        end else if (accept) begin
            memresp_msg.type_  <= memreq_msg.type_;
            memresp_msg.opaque <= memreq_msg.opaque;
            memresp_msg.test   <= 2'd0;
            memresp_msg.len    <= 4'd0;
            memresp_msg.data   <= (memreq_msg.type_ == MEM_TYPE_READ) ? store[idx] : '0;
        end
    end

`ifdef LINE_MEM_STATS_EN
    // Accepted-request counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_reads  <= '0;
            num_writes <= '0;
        end else if (accept) begin
            if (memreq_msg.type_ == MEM_TYPE_READ)
                num_reads <= num_reads + 32'd1;
            if (is_write(memreq_msg.type_))
                num_writes <= num_writes + 32'd1;
        end
    end
`endif

endmodule
